conv_window_seq: RTL and testbench

Window sequencer that sits directly upstream of the convolution accumulator. It walks a K×K window across a row-major IMG_W×IMG_H 8-bit image held in synchronous RAM. For each valid window position it emits the pixel read addresses, the matching binary kernel bit (`ker_val`), an accumulator-clear strobe (`res_rst`), and a result-valid strobe carrying the output pixel index. It has no padding: the output is (IMG_W−K+1)×(IMG_H−K+1).

---
 rtl/conv_window_seq_if.sv | 41 ++++
 rtl/conv_window_seq.sv | 204 ++++++++++++++++++++
 tb/tb_conv_window_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/conv_window_seq_if.sv
// conv_window_seq_if
//   Bundles the sequencer's command inputs and its RAM/accumulator-facing
//   outputs into one port.
//   master : the window sequencer (drives RAM address, kernel tap, strobes)
//   slave  : the surrounding system (issues start/kernel, consumes outputs)
// Signals:
//   start      frame request, sampled only while the sequencer is idle
//   kernel     K*K binary kernel mask, bit (kr*K+kc), bit 0 = top-left
//   ram_addr   pixel read address (RAM has 1-cycle read latency)
//   ram_en     RAM read enable
//   ker_val    kernel bit aligned with the RAM data currently returned
//   res_rst    clear the accumulator for the next window
//   res_valid  accumulator holds a finished window sum this cycle
//   out_addr   output pixel index, valid with res_valid
//   busy       frame in progress
//   done       one-cycle pulse at frame end
interface conv_window_seq_if #(
    parameter int K  = 3,
    parameter int AW = 6
) ();
    logic              start;
    logic [K*K-1:0]    kernel;
    logic [AW-1:0]     ram_addr;
    logic              ram_en;
    logic              ker_val;
    logic              res_rst;
    logic              res_valid;
    logic [AW-1:0]     out_addr;
    logic              busy;
    logic              done;

    modport master (
        input  start, kernel,
        output ram_addr, ram_en, ker_val, res_rst, res_valid, out_addr, busy, done
    );

    modport slave (
        output start, kernel,
        input  ram_addr, ram_en, ker_val, res_rst, res_valid, out_addr, busy, done
    );
endinterface

// File: rtl/conv_window_seq.sv
// conv_window_seq
//   Walks a KxK window over a row-major IMG_W x IMG_H image held in a
//   synchronous RAM, without padding. For every window it clears the
//   downstream accumulator, issues the K*K pixel reads together with the
//   matching kernel bit (delayed one cycle to line up with RAM data), waits
//   for the last read to return, then flags the finished sum with its
//   output pixel index. Every output is a register.
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset; abandons any frame in progress
//   bus   conv_window_seq_if.master (start/kernel in; RAM address/enable,
//         ker_val, res_rst, res_valid, out_addr, busy, done out)
module conv_window_seq #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int K     = 3,
    parameter int AW    = 6
) (
    input  logic                   clk,
    input  logic                   rstn,
    conv_window_seq_if.master      bus
);

    localparam int KK    = K * K;
    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;

    localparam logic [AW-1:0] ONE      = AW'(1);
    localparam logic [AW-1:0] K_A      = AW'(K);
    localparam logic [AW-1:0] K_LAST   = AW'(K - 1);
    localparam logic [AW-1:0] IMG_W_A  = AW'(IMG_W);
    localparam logic [AW-1:0] OUT_W_A  = AW'(OUT_W);
    localparam logic [AW-1:0] COL_LAST = AW'(OUT_W - 1);
    localparam logic [AW-1:0] ROW_LAST = AW'(OUT_H - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        TAP,
        FLUSH,
        WRITE,
        DONE
    } state_t;

    state_t          state_q;
    logic [KK-1:0]   kernel_q;
    logic [AW-1:0]   win_row_q;
    logic [AW-1:0]   win_col_q;
    logic [AW-1:0]   kr_q;
    logic [AW-1:0]   kc_q;
    logic [AW-1:0]   ram_addr_q;
    logic [AW-1:0]   out_addr_q;
    logic            ram_en_q;
    logic            ker_val_q;
    logic            res_rst_q;
    logic            res_valid_q;
    logic            busy_q;
    logic            done_q;

    logic [AW-1:0]   kr_d;
    logic [AW-1:0]   kc_d;
    logic [AW-1:0]   win_row_d;
    logic [AW-1:0]   win_col_d;
    logic [AW-1:0]   first_addr_d;
    logic [AW-1:0]   tap_addr_d;
    logic [AW-1:0]   out_addr_d;
    logic [AW-1:0]   tap_idx;
    logic [KK-1:0]   ker_shift;
    logic            ker_bit;
    logic            last_tap;
    logic            last_win;

    // Counter successors and address arithmetic. All products stay below
    // IMG_W*IMG_H, which fits AW bits, so AW-wide unsigned math is exact.
    always_comb begin
        last_tap = (kr_q == K_LAST) && (kc_q == K_LAST);
        last_win = (win_row_q == ROW_LAST) && (win_col_q == COL_LAST);

        kr_d = kr_q;
        kc_d = kc_q + ONE;
        if (kc_q == K_LAST) begin
            kc_d = '0;
            kr_d = kr_q + ONE;
        end

        win_row_d = win_row_q;
        win_col_d = win_col_q + ONE;
        if (win_col_q == COL_LAST) begin
            win_col_d = '0;
            win_row_d = win_row_q + ONE;
        end

        first_addr_d = win_row_q * IMG_W_A + win_col_q;
        // Only consumed when the current tap is not the last one, so kr_d
        // never runs past K-1 here.
        tap_addr_d   = (win_row_q + kr_d) * IMG_W_A + win_col_q + kc_d;
        out_addr_d   = win_row_q * OUT_W_A + win_col_q;

        tap_idx   = kr_q * K_A + kc_q;
        ker_shift = kernel_q >> tap_idx;
        ker_bit   = ker_shift[0];
    end

    // Control FSM. Outputs are loaded on the edge that enters the state in
    // which they must be visible, so each output reflects its state exactly.
    // ker_val is loaded during TAP with the bit of the tap being read, so it
    // lands in the same cycle as that tap's RAM data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            kernel_q    <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            kr_q        <= '0;
            kc_q        <= '0;
            ram_addr_q  <= '0;
            out_addr_q  <= '0;
            ram_en_q    <= 1'b0;
            ker_val_q   <= 1'b0;
            res_rst_q   <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ker_val_q <= 1'b0;
                    if (bus.start) begin
                        kernel_q  <= bus.kernel;
                        win_row_q <= '0;
                        win_col_q <= '0;
                        kr_q      <= '0;
                        kc_q      <= '0;
                        busy_q    <= 1'b1;
                        res_rst_q <= 1'b1;
                        state_q   <= CLEAR;
                    end
                end

                CLEAR: begin
                    res_rst_q  <= 1'b0;
                    kr_q       <= '0;
                    kc_q       <= '0;
                    ram_en_q   <= 1'b1;
                    ram_addr_q <= first_addr_d;
                    ker_val_q  <= 1'b0;
                    state_q    <= TAP;
                end

                TAP: begin
                    ker_val_q <= ker_bit;
                    if (last_tap) begin
                        ram_en_q <= 1'b0;
                        state_q  <= FLUSH;
                    end else begin
                        kr_q       <= kr_d;
                        kc_q       <= kc_d;
                        ram_addr_q <= tap_addr_d;
                    end
                end

                FLUSH: begin
                    ker_val_q   <= 1'b0;
                    res_valid_q <= 1'b1;
                    out_addr_q  <= out_addr_d;
                    state_q     <= WRITE;
                end

                WRITE: begin
                    res_valid_q <= 1'b0;
                    if (last_win) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        win_row_q <= win_row_d;
                        win_col_q <= win_col_d;
                        res_rst_q <= 1'b1;
                        state_q   <= CLEAR;
                    end
                end

                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_en    = ram_en_q;
    assign bus.ker_val   = ker_val_q;
    assign bus.res_rst   = res_rst_q;
    assign bus.res_valid = res_valid_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_conv_window_seq.sv
module tb_conv_window_seq;

    logic clk;
    logic rstn;

    conv_window_seq_if #(.K(3), .AW(6)) bus ();

    conv_window_seq #(
        .IMG_W (8),
        .IMG_H (8),
        .K     (3),
        .AW    (6)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Image RAM: pixel value equals its address, 1-cycle read latency.
    logic [7:0] img_q;
    initial img_q = 8'd0;
    always @(posedge clk) begin
        if (bus.ram_en) img_q <= 8'(bus.ram_addr);
    end

    // Consumer accumulator working on the falling edge.
    int acc;
    initial acc = 0;
    always @(negedge clk) begin
        if (bus.res_rst) acc <= 0;
        else if (bus.ker_val) acc <= acc + int'(img_q);
    end

    int ncmp;
    int nerr;
    int cyc;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp = ncmp + 1;
        assert (obs === exp) else begin
            nerr = nerr + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ram_addr"},  32'(bus.ram_addr),  32'd0);
        chk({tag, "_out_addr"},  32'(bus.out_addr),  32'd0);
        chk({tag, "_ram_en"},    32'(bus.ram_en),    32'd0);
        chk({tag, "_ker_val"},   32'(bus.ker_val),   32'd0);
        chk({tag, "_res_rst"},   32'(bus.res_rst),   32'd0);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        chk({tag, "_busy"},      32'(bus.busy),      32'd0);
        chk({tag, "_done"},      32'(bus.done),      32'd0);
    endtask

    // Starts a frame from idle and checks window 0 cycle by cycle.
    // Leaves the bench in the WRITE cycle of window 0 with cyc = 12.
    task automatic win0(input string tag, input logic [8:0] ker, input int exp_sum);
        int exp_a[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
        logic [31:0] kv;
        bus.kernel = ker;
        bus.start  = 1'b1;
        cyc = 0;
        tick();
        bus.start = 1'b0;
        chk({tag, "_clear_res_rst"}, 32'(bus.res_rst), 32'd1);
        chk({tag, "_clear_busy"},    32'(bus.busy),    32'd1);
        chk({tag, "_clear_ram_en"},  32'(bus.ram_en),  32'd0);
        for (int i = 0; i < 9; i++) begin
            tick();
            kv = 32'd0;
            if (i > 0) kv = 32'(ker[i-1]);
            chk({tag, "_tap_ram_addr"}, 32'(bus.ram_addr), 32'(exp_a[i]));
            chk({tag, "_tap_ram_en"},   32'(bus.ram_en),   32'd1);
            chk({tag, "_tap_ker_val"},  32'(bus.ker_val),  kv);
            chk({tag, "_tap_res_rst"},  32'(bus.res_rst),  32'd0);
        end
        tick();
        chk({tag, "_flush_ram_en"},  32'(bus.ram_en),    32'd0);
        chk({tag, "_flush_ker_val"}, 32'(bus.ker_val),   32'(ker[8]));
        chk({tag, "_flush_rvalid"},  32'(bus.res_valid), 32'd0);
        tick();
        chk({tag, "_write_res_valid"}, 32'(bus.res_valid), 32'd1);
        chk({tag, "_write_out_addr"},  32'(bus.out_addr),  32'd0);
        chk({tag, "_write_sum"},       32'(acc),           32'(exp_sum));
        chk({tag, "_write_ker_val"},   32'(bus.ker_val),   32'd0);
    endtask

    initial begin
        int  nwin;
        bit  seen_clr;
        bit  got_done;
        int  nrv;
        int  ndn;
        int  nbusy;

        ncmp = 0;
        nerr = 0;
        cyc  = 0;

        // Reset held with start asserted: nothing may move.
        rstn       = 1'b0;
        bus.start  = 1'b1;
        bus.kernel = 9'h1FF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all_zero("rst");
        end
        bus.start = 1'b0;
        rstn      = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("idle_busy",    32'(bus.busy),    32'd0);
        chk("idle_ram_en",  32'(bus.ram_en),  32'd0);
        chk("idle_res_rst", 32'(bus.res_rst), 32'd0);

        // Full frame, all-ones kernel. A start pulse with a zero kernel lands
        // mid-frame and the kernel input stays zero afterwards: sums must not
        // change.
        win0("full", 9'h1FF, 81);
        nwin     = 1;
        seen_clr = 1'b0;
        got_done = 1'b0;
        while (!got_done && cyc < 600) begin
            tick();
            if (cyc == 50) begin
                bus.start  = 1'b1;
                bus.kernel = 9'h000;
            end
            if (cyc == 51) bus.start = 1'b0;
            if (seen_clr) begin
                chk("first_ram_addr", 32'(bus.ram_addr), 32'((nwin / 6) * 8 + (nwin % 6)));
                seen_clr = 1'b0;
            end
            if (bus.res_rst) seen_clr = 1'b1;
            if (bus.res_valid) begin
                chk("out_addr", 32'(bus.out_addr), 32'(nwin));
                chk("win_sum",  32'(acc), 32'(72 * (nwin / 6) + 9 * (nwin % 6) + 81));
                nwin = nwin + 1;
            end
            if (bus.done) got_done = 1'b1;
        end
        chk("done_cycle",  32'(cyc),  32'd433);
        chk("win_count",   32'(nwin), 32'd36);
        chk("done_busy",   32'(bus.busy), 32'd1);
        tick();
        chk("post_done",   32'(bus.done), 32'd0);
        chk("post_busy",   32'(bus.busy), 32'd0);

        // Center-only kernel, then reset pulse mid-frame.
        win0("center", 9'h010, 9);
        while (cyc < 100) tick();
        rstn = 1'b0;
        #1;
        chk_all_zero("midrst");
        #2;
        rstn = 1'b1;
        nrv   = 0;
        ndn   = 0;
        nbusy = 0;
        for (int i = 0; i < 450; i++) begin
            tick();
            if (bus.res_valid) nrv = nrv + 1;
            if (bus.done) ndn = ndn + 1;
            if (bus.busy) nbusy = nbusy + 1;
        end
        chk("abandon_res_valid", 32'(nrv),   32'd0);
        chk("abandon_done",      32'(ndn),   32'd0);
        chk("abandon_busy",      32'(nbusy), 32'd0);

        // Fresh start after the abandoned frame reproduces window 0.
        win0("restart", 9'h1FF, 81);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
